bp_update_queue: RTL and testbench
==================================

// Module: bp_update_queue
// PURPOSE
//  Decouples branch resolution from branch-predictor table updates. Buffers resolved
//  branch outcomes (pc, taken, target) as FIFO entries. Drains them in order, one per
//  cycle, into the predictor update port whenever the predictor is not stalled.
//  Sits between the ID/EX branch-resolve logic and the gshare/BTB update inputs.
// PARAMETERS
//  DEPTH   4   entry count; power of two, >= 2
//  PC_W    32  width of pc and target fields
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous, active-high reset
//  clear          in   1            sync discard of all queued entries (predictor re-init)
//  res_valid      in   1            resolved branch presented
//  res_pc         in   PC_W         pc of resolved branch
//  res_taken      in   1            actual branch outcome
//  res_target     in   PC_W         actual next pc when taken
//  res_mispred    in   1            pipeline mispredicted this branch (stats only)
//  res_ready      out  1            queue can accept; = !full
//  upd_valid      out  1            head entry valid toward predictor
//  upd_pc         out  PC_W         head pc
//  upd_taken      out  1            head outcome
//  upd_target     out  PC_W         head target
//  upd_ready      in   1            predictor consumes head this cycle (= !is_stall)
//  occupancy      out  log2(DEPTH)+1 current entry count
//  overflow       out  1            sticky: res_valid seen while full
// BEHAVIOUR
//  - Storage: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits, wrap modulo DEPTH;
//    count register 0..DEPTH; full = (count==DEPTH), empty = (count==0).
//  - Push: res_valid & res_ready at posedge -> entry written at wr_ptr, wr_ptr+1.
//  - Pop: upd_valid & upd_ready at posedge -> rd_ptr+1.
//  - upd_* driven combinationally from entry[rd_ptr]; upd_valid = !empty. No bypass:
//    an entry pushed in cycle N is visible on upd_* in cycle N+1 at earliest.
//  - Simultaneous push+pop: count unchanged, both pointers advance. When full, res_ready=0
//    even if a pop occurs in the same cycle (no pop-through).
//  - Push while full: entry dropped, overflow set to 1; overflow clears only on reset.
//  - Pop while empty: ignored (no pointer move); upd_* hold stale but upd_valid=0.
//  - Order preserved strictly FIFO; upd_* payload stable while upd_valid & !upd_ready.
//  - Priority per cycle: reset > clear > push/pop.
//  - clear: pointers and count -> 0 this edge; a same-cycle push is discarded;
//    overflow untouched.
//  - Reset (also mid-operation): wr_ptr=rd_ptr=0, count=0, overflow=0, all entries
//    zeroed -> upd_valid=0, upd_pc=upd_target=0, upd_taken=0, occupancy=0, res_ready=1.
// CONFIGURATION
//  BP_PERF_CNT_EN defined: adds outputs perf_branches[31:0], perf_mispreds[31:0].
//    perf_branches +1 per accepted push; perf_mispreds +1 per accepted push with
//    res_mispred=1. Both wrap at 2^32, reset to 0 on reset, not affected by clear.
//    Dropped (overflow) pushes are not counted.
//  Undefined: ports and counters absent; res_mispred ignored; all other behaviour identical.
// TESTING
//  1 reset, then push pc=0x100 taken=1 tgt=0x200, upd_ready=1 -> upd_valid=1 next cycle
//    with 0x100/1/0x200, occupancy 1->0 after pop.
//  2 upd_ready=0, push 4 entries pc=0x10,0x14,0x18,0x1C -> occupancy=4, res_ready=0;
//    5th push -> dropped, overflow=1; release upd_ready -> pops 0x10..0x1C in order.
//  3 occupancy=2, push+pop same cycle for 6 cycles -> occupancy stays 2, pointers wrap,
//    FIFO order kept.
//  4 full queue with upd_ready=1 and res_valid=1 -> pop occurs, push rejected (res_ready=0),
//    occupancy=3.
//  5 occupancy=3, assert clear with res_valid=1 -> occupancy=0, upd_valid=0,
//    overflow unchanged; then reset mid-drain -> all outputs at reset values.
//  6 BP_PERF_CNT_EN: 5 accepted pushes, 2 with res_mispred=1, 1 dropped while full ->
//    perf_branches=5, perf_mispreds=2; clear leaves them, reset zeroes them.

Source files
------------

// File: rtl/bp_update_queue.sv
// bp_update_queue: in-order FIFO that buffers resolved branches and feeds them to the predictor update port.
// Define BP_PERF_CNT_EN to add the perf_branches/perf_mispreds counters.
module bp_update_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       res_valid,
  input  logic [PC_W-1:0]            res_pc,
  input  logic                       res_taken,
  input  logic [PC_W-1:0]            res_target,
  input  logic                       res_mispred,
  output logic                       res_ready,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_taken,
  output logic [PC_W-1:0]            upd_target,
  input  logic                       upd_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]                perf_branches,
  output logic [31:0]                perf_mispreds
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [PC_W-1:0] target_q [DEPTH];
  logic [DEPTH-1:0] taken_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, push, pop;
  assign full = count == (AW+1)'(DEPTH);
  assign res_ready = ~full;
  assign upd_valid = count != '0;
  assign push = res_valid & ~full;
  assign pop = upd_valid & upd_ready;
  assign upd_pc = pc_q[rd_ptr];
  assign upd_taken = taken_q[rd_ptr];
  assign upd_target = target_q[rd_ptr];
  assign occupancy = count;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      taken_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        target_q[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (res_valid && full) overflow <= 1'b1;
      if (push) begin
        pc_q[wr_ptr] <= res_pc;
        taken_q[wr_ptr] <= res_taken;
        target_q[wr_ptr] <= res_target;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef BP_PERF_CNT_EN
  // Only pushes that actually land in the queue are counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches <= '0;
      perf_mispreds <= '0;
    end else if (push && !clear) begin
      perf_branches <= perf_branches + 32'd1;
      perf_mispreds <= perf_mispreds + 32'(res_mispred);
    end
  end
`else
  logic unused_mispred;
  assign unused_mispred = res_mispred;
`endif
endmodule

// File: tb/tb_bp_update_queue.sv
// tb_bp_update_queue: directed stimulus checked every cycle against a queue-based reference model.
module tb_bp_update_queue;
  localparam int DEPTH = 4;
  localparam int PC_W = 32;
  logic clk = 1'b0;
  logic reset, clear, res_valid, res_taken, res_mispred, upd_ready;
  logic [PC_W-1:0] res_pc, res_target;
  logic res_ready, upd_valid, upd_taken, overflow;
  logic [PC_W-1:0] upd_pc, upd_target;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispreds;
`endif
  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  bp_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_mispred(res_mispred), .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_ready(upd_ready),
    .occupancy(occupancy), .overflow(overflow)
`ifdef BP_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispreds(perf_mispreds)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic taken;
    logic [PC_W-1:0] target;
  } entry_t;
  entry_t q[$];
  bit m_ovf = 1'b0;
  int unsigned m_branches = 0;
  int unsigned m_mispreds = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_branches = 0;
      m_mispreds = 0;
    end else if (clear) begin
      q.delete();
    end else begin
      bit was_full;
      was_full = q.size() == DEPTH;
      if (res_valid && was_full) m_ovf = 1'b1;
      if (q.size() > 0 && upd_ready) void'(q.pop_front());
      if (res_valid && !was_full) begin
        q.push_back('{res_pc, res_taken, res_target});
        m_branches++;
        if (res_mispred) m_mispreds++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("res_ready", 64'(res_ready), 64'(q.size() != DEPTH));
      chk("upd_valid", 64'(upd_valid), 64'(q.size() != 0));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (q.size() != 0) begin
        chk("upd_pc", 64'(upd_pc), 64'(q[0].pc));
        chk("upd_taken", 64'(upd_taken), 64'(q[0].taken));
        chk("upd_target", 64'(upd_target), 64'(q[0].target));
      end
`ifdef BP_PERF_CNT_EN
      chk("perf_branches", 64'(perf_branches), 64'(m_branches));
      chk("perf_mispreds", 64'(perf_mispreds), 64'(m_mispreds));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic tk,
                       input logic [PC_W-1:0] tg, input logic mp);
    res_valid = v;
    res_pc = pc;
    res_taken = tk;
    res_target = tg;
    res_mispred = mp;
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    upd_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    chk_en = 1'b1;
    chk("rst upd_valid", 64'(upd_valid), 64'd0);
    chk("rst upd_pc", 64'(upd_pc), 64'd0);
    chk("rst upd_target", 64'(upd_target), 64'd0);
    chk("rst occupancy", 64'(occupancy), 64'd0);
    chk("rst res_ready", 64'(res_ready), 64'd1);
    step();
    reset = 1'b0;

    // 1: single push then pop
    upd_ready = 1'b1;
    drive(1, 32'h100, 1, 32'h200, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("t1 upd_valid", 64'(upd_valid), 64'd1);
    chk("t1 upd_pc", 64'(upd_pc), 64'h100);
    chk("t1 upd_taken", 64'(upd_taken), 64'd1);
    chk("t1 upd_target", 64'(upd_target), 64'h200);
    chk("t1 occupancy", 64'(occupancy), 64'd1);
    step();
    chk("t1 occupancy after pop", 64'(occupancy), 64'd0);

    // 2: fill while stalled, overflow, drain in order
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h10 + 32'(4 * i), 1'(i), 32'h1000 + 32'(i), 0);
      step();
    end
    chk("t2 occupancy full", 64'(occupancy), 64'd4);
    chk("t2 res_ready full", 64'(res_ready), 64'd0);
    drive(1, 32'h20, 1, 32'h2000, 0);
    step();
    chk("t2 overflow", 64'(overflow), 64'd1);
    chk("t2 occupancy after drop", 64'(occupancy), 64'd4);
    chk("t2 stalled head", 64'(upd_pc), 64'h10);
    drive(0, 0, 0, 0, 0);
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2 drain pc", 64'(upd_pc), 64'h10 + 64'(4 * i));
      step();
    end
    chk("t2 occupancy drained", 64'(occupancy), 64'd0);

    // 3: steady push+pop at occupancy 2, pointers wrap
    upd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h30 + 32'(4 * i), 0, 32'h3000 + 32'(i), 0);
      step();
    end
    upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h38 + 32'(4 * i), 1'(i), 32'h3100 + 32'(i), 0);
      chk("t3 head", 64'(upd_pc), 64'h30 + 64'(4 * i));
      step();
      chk("t3 occupancy", 64'(occupancy), 64'd2);
    end
    chk("t3 head after", 64'(upd_pc), 64'h48);

    // 4: full with pop and push in same cycle -> push rejected
    drive(0, 0, 0, 0, 0);
    step();
    step();
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h50 + 32'(4 * i), 1, 32'h5000 + 32'(i), 0);
      step();
    end
    drive(1, 32'h60, 1, 32'h6000, 0);
    upd_ready = 1'b1;
    step();
    chk("t4 occupancy", 64'(occupancy), 64'd3);
    chk("t4 head", 64'(upd_pc), 64'h54);

    // 5: clear with a push pending, then reset mid-drain
    upd_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("t5 clear occupancy", 64'(occupancy), 64'd0);
    chk("t5 clear upd_valid", 64'(upd_valid), 64'd0);
    chk("t5 clear overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h70 + 32'(4 * i), 1, 32'h7000 + 32'(i), 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    upd_ready = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5 rst upd_valid", 64'(upd_valid), 64'd0);
    chk("t5 rst upd_pc", 64'(upd_pc), 64'd0);
    chk("t5 rst upd_taken", 64'(upd_taken), 64'd0);
    chk("t5 rst upd_target", 64'(upd_target), 64'd0);
    chk("t5 rst occupancy", 64'(occupancy), 64'd0);
    chk("t5 rst overflow", 64'(overflow), 64'd0);
    chk("t5 rst res_ready", 64'(res_ready), 64'd1);

    // 6: perf counters (model checks them each cycle when enabled)
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h80 + 32'(4 * i), 0, 32'h8000 + 32'(i), 1'(i == 1));
      step();
    end
    drive(1, 32'h90, 0, 32'h9000, 1);
    step();
    drive(0, 0, 0, 0, 0);
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0;
    drive(1, 32'h94, 1, 32'h9400, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("t6 occupancy", 64'(occupancy), 64'd4);
`ifdef BP_PERF_CNT_EN
    chk("t6 perf_branches", 64'(perf_branches), 64'd5);
    chk("t6 perf_mispreds", 64'(perf_mispreds), 64'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6 clear perf_branches", 64'(perf_branches), 64'd5);
    chk("t6 clear perf_mispreds", 64'(perf_mispreds), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6 rst perf_branches", 64'(perf_branches), 64'd0);
    chk("t6 rst perf_mispreds", 64'(perf_mispreds), 64'd0);
`endif
    upd_ready = 1'b1;
    repeat (6) step();
    chk("end occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
